// File: rtl/fp_adder_stage2_if.sv
// Bundle of signals between FP adder stage 1 and stage 2.
// The stage-1 side drives the add1_* operands plus valid_i/stall_i through
// the master modport. The stage-2 side returns the registered add2_* results
// through the slave modport.
interface fp_adder_stage2_if #(
  parameter int EXPONENT_WIDTH    = 8,
  parameter int SIGNIFICAND_WIDTH = 23
);
  localparam int SW3 = SIGNIFICAND_WIDTH + 3;

  logic                      valid_i;
  logic                      stall_i;
  logic [5:0]                add1_operand_align_shift;
  logic [SW3-1:0]            add1_significand1;
  logic [SW3-1:0]            add1_significand2;
  logic [EXPONENT_WIDTH-1:0] add1_exponent1;
  logic [EXPONENT_WIDTH-1:0] add1_exponent2;
  logic                      add1_result_is_inf;
  logic                      add1_result_is_nan;
  logic                      add1_exponent2_larger;

  logic                      add2_valid;
  logic [SW3-1:0]            add2_significand;
  logic [EXPONENT_WIDTH-1:0] add2_exponent;
  logic                      add2_result_is_inf;
  logic                      add2_result_is_nan;
  logic                      add2_sticky;

  modport master (
    output valid_i, stall_i, add1_operand_align_shift,
           add1_significand1, add1_significand2,
           add1_exponent1, add1_exponent2,
           add1_result_is_inf, add1_result_is_nan, add1_exponent2_larger,
    input  add2_valid, add2_significand, add2_exponent,
           add2_result_is_inf, add2_result_is_nan, add2_sticky
  );

  modport slave (
    input  valid_i, stall_i, add1_operand_align_shift,
           add1_significand1, add1_significand2,
           add1_exponent1, add1_exponent2,
           add1_result_is_inf, add1_result_is_nan, add1_exponent2_larger,
    output add2_valid, add2_significand, add2_exponent,
           add2_result_is_inf, add2_result_is_nan, add2_sticky
  );
endinterface

// File: rtl/fp_adder_stage2.sv
// FP adder stage 2: align the smaller-exponent significand and add it.
// The smaller significand is arithmetically right-shifted, then added to the
// larger one. The result exponent is selected and the inf/nan flags are
// registered. The stage has one cycle of latency and can be stalled.
// Optional macro FP_ADD_STICKY_EN adds the sticky bit, which is the OR of
// the bits lost during alignment. Without the macro, add2_sticky is tied to 0.
module fp_adder_stage2 #(
  parameter int EXPONENT_WIDTH    = 8,
  parameter int SIGNIFICAND_WIDTH = 23
) (
  input  logic             clk,
  input  logic             reset_n,
  fp_adder_stage2_if.slave bus
);
  localparam int SW3 = SIGNIFICAND_WIDTH + 3;

  logic                      w_shift_all;
  logic [SW3-1:0]            w_aligned2;
  logic [SW3-1:0]            w_sum;
  logic [EXPONENT_WIDTH-1:0] w_exponent;

  logic                      r_valid;
  logic [SW3-1:0]            r_significand;
  logic [EXPONENT_WIDTH-1:0] r_exponent;
  logic                      r_inf;
  logic                      r_nan;

  // A shift of SW3 or more moves every bit out, leaving only sign copies.
  assign w_shift_all = (32'(bus.add1_operand_align_shift) >= SW3);

  // Sign-filled alignment of the smaller-exponent significand.
  always_comb begin
    w_aligned2 = '0;
    if (w_shift_all)
      w_aligned2 = {SW3{bus.add1_significand2[SW3-1]}};
    else
      w_aligned2 = $signed(bus.add1_significand2) >>> bus.add1_operand_align_shift;
  end

  // The two guard bits leave room for the sum, so plain truncation is safe.
  assign w_sum      = bus.add1_significand1 + w_aligned2;
  assign w_exponent = bus.add1_exponent2_larger ? bus.add1_exponent2 : bus.add1_exponent1;

  // Valid flag: frozen while stalled, otherwise follows valid_i.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_valid <= 1'b0;
    else if (!bus.stall_i)
      r_valid <= bus.valid_i;
  end

  // Result payload: loads only for a live, unstalled operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_significand <= '0;
      r_exponent    <= '0;
      r_inf         <= 1'b0;
      r_nan         <= 1'b0;
    end else if (!bus.stall_i && bus.valid_i) begin
      r_significand <= w_sum;
      r_exponent    <= w_exponent;
      r_inf         <= bus.add1_result_is_inf;
      r_nan         <= bus.add1_result_is_nan;
    end
  end

  assign bus.add2_valid         = r_valid;
  assign bus.add2_significand   = r_significand;
  assign bus.add2_exponent      = r_exponent;
  assign bus.add2_result_is_inf = r_inf;
  assign bus.add2_result_is_nan = r_nan;

`ifdef FP_ADD_STICKY_EN
  logic [SW3-1:0] w_lost_mask;
  logic           w_sticky;
  logic           r_sticky;

  // Bit gi is lost when the shift amount exceeds gi.
  // A shift of SW3 or more therefore covers every bit.
  for (genvar gi = 0; gi < SW3; gi++) begin : g_lost_mask
    assign w_lost_mask[gi] = (32'(bus.add1_operand_align_shift) > gi);
  end

  assign w_sticky = |(bus.add1_significand2 & w_lost_mask);

  // Sticky bit follows the same load/hold rule as the payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_sticky <= 1'b0;
    else if (!bus.stall_i && bus.valid_i)
      r_sticky <= w_sticky;
  end

  assign bus.add2_sticky = r_sticky;
`else
  assign bus.add2_sticky = 1'b0;
`endif

endmodule

// File: doc/fp_adder_stage2.md
FP_ADDER_STAGE2 -- requirements
Module: fp_adder_stage2

Interface
REQ-001 SHALL have parameter EXPONENT_WIDTH, default 8, exponent field width.
REQ-002 SHALL have parameter SIGNIFICAND_WIDTH, default 23, stored fraction width; SW3 below denotes SIGNIFICAND_WIDTH+3.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port valid_i  input  1  stage-1 outputs carry a live operation.
REQ-006 SHALL have port stall_i  input  1  downstream not accepting; hold all output registers.
REQ-007 SHALL have port add1_operand_align_shift  input  6  unsigned exponent-difference magnitude.
REQ-008 SHALL have port add1_significand1  input  SW3  two's-complement larger-exponent significand.
REQ-009 SHALL have port add1_significand2  input  SW3  two's-complement smaller-exponent significand.
REQ-010 SHALL have ports add1_exponent1, add1_exponent2  input  EXPONENT_WIDTH  raw operand exponents.
REQ-011 SHALL have ports add1_result_is_inf, add1_result_is_nan, add1_exponent2_larger  input  1 each  stage-1 flags.
REQ-012 SHALL have port add2_valid  output  1  registered result valid.
REQ-013 SHALL have port add2_significand  output  SW3  registered two's-complement sum.
REQ-014 SHALL have port add2_exponent  output  EXPONENT_WIDTH  registered result exponent (pre-normalization).
REQ-015 SHALL have ports add2_result_is_inf, add2_result_is_nan  output  1 each  registered flag passthrough.
REQ-016 SHALL have port add2_sticky  output  1  OR of bits shifted out during alignment.

Function
REQ-017 SHALL compute aligned2 = add1_significand2 arithmetically right-shifted (sign-filled) by add1_operand_align_shift.
REQ-018 SHALL, for shift >= SW3 (26..63 at defaults), produce aligned2 of all copies of add1_significand2 MSB (0 or all-ones).
REQ-019 SHALL compute sum = add1_significand1 + aligned2 truncated to SW3 bits; no overflow flag (two guard bits guarantee fit).
REQ-020 SHALL select result exponent = add1_exponent2 when add1_exponent2_larger=1, else add1_exponent1.
REQ-021 SHALL have latency exactly 1 cycle: inputs at edge N visible on outputs after edge N when not stalled.
REQ-022 SHALL, with stall_i=1, hold every output register including add2_valid, regardless of valid_i.
REQ-023 SHALL, with stall_i=0, load add2_valid <= valid_i.
REQ-024 SHALL, with stall_i=0 and valid_i=1, load significand, exponent, inf, nan and sticky registers; with valid_i=0 hold them.
REQ-025 SHALL pass inf/nan flags unmodified; sum and exponent still computed when either flag set.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force all output registers to 0, independent of clk and stall_i.
REQ-027 SHALL discard any in-flight operation on reset; first valid output after release requires valid_i=1 on a post-release edge.

Configuration
REQ-028 SHALL compile sticky logic only when macro FP_ADD_STICKY_EN is defined.
REQ-029 SHALL, with FP_ADD_STICKY_EN, set sticky = OR of add1_significand2 bits [shift-1:0] (all SW3 bits when shift >= SW3; 0 when shift=0).
REQ-030 SHALL, without FP_ADD_STICKY_EN, drive add2_sticky constant 0 and contain no sticky registers.

Verification
REQ-031 SHALL test 1.0+1.0: sig1=sig2=0x0800000, exp1=exp2=127, shift=0, valid_i=1 -> next cycle sum=0x1000000, exponent=127, add2_valid=1, sticky=0.
REQ-032 SHALL test 1.0+0.5: sig1=0x0800000, sig2=0x0800000, exp 127/126, shift=1 -> sum=0x0C00000, exponent=127; then sig2=0x0800001 -> sticky=1 (macro on), 0 (macro off).
REQ-033 SHALL test 1.0-1.0: sig1=0x0800000, sig2=0x3800000, shift=0 -> sum=0x0000000, exponent=127.
REQ-034 SHALL test oversize shift: sig1=0x0800000, sig2=0x3800000, shift=40, exponent1_larger -> aligned2=0x3FFFFFF, sum=0x07FFFFF, sticky=1 (macro on).
REQ-035 SHALL test stall: load result A, assert stall_i 3 cycles with new inputs B -> outputs stay A; deassert -> B appears next edge.
REQ-036 SHALL test reset mid-operation: valid_i=1 pending, pull reset_n low between edges -> all outputs 0 immediately, add2_valid stays 0 until a valid post-release edge.
